regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/a3/wd3) between N_REQ writeback requesters, e.g. ALU, load unit and CSR/mult unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards against writes that have been reserved but not yet committed.
- Sits between the writeback sources and the register file's write port.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a write pending
req_ready  out  N_REQ  requester i granted this cycle (combinational)
req_addr  in  N_REQ*ADDR_W  flattened destination register, slice i = [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  flattened write data, slice i = [i*DATA_W +: DATA_W]
rsv_valid  in  1  decode reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
chk_a1  in  ADDR_W  source register 1 to check
chk_a2  in  ADDR_W  source register 2 to check
busy1  out  1  chk_a1 has a pending write (combinational)
busy2  out  1  chk_a2 has a pending write (combinational)
we3  out  1  register-file write enable (registered)
a3  out  ADDR_W  register-file write address (registered)
wd3  out  DATA_W  register-file write data (registered)

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous, active low. On reset: we3=0, a3=0, wd3=0, rr_ptr=0, busy vector all 0. req_ready then follows the combinational rules from the reset state.
- Arbitration: combinational. Search req_valid starting at index rr_ptr and wrapping modulo N_REQ; the first set bit wins. req_ready is one-hot or zero. A transfer occurs when req_valid[i] && req_ready[i].
- rr_ptr update: on a transfer, rr_ptr <= (winner+1) mod N_REQ. With no transfer, rr_ptr holds.
- Fairness: a requester holding valid is granted within N_REQ cycles.
- Requester obligation: valid, addr and data stay stable until ready. Deasserting valid before ready is legal; the request is simply withdrawn.
- Output stage: one register, so latency is 1 cycle from transfer to we3. The register file captures the write on the following edge.
- Output register update each edge:
  - Transfer with addr != 0: we3<=1, a3<=addr, wd3<=data.
  - Otherwise: we3<=0; a3 and wd3 hold their previous values.
- Register x0: a transfer to address 0 is accepted (ready asserted) and discarded. we3 stays 0 and the scoreboard is untouched.
- Throughput: at most one write per cycle. The write port has no backpressure.
- Scoreboard set: on rsv_valid && rsv_addr != 0, busy[rsv_addr] <= 1.
- Scoreboard clear: when we3==1, busy[a3] <= 0. The bit clears on the same edge the register file captures wd3.
- Set/clear collision: if a set and a clear hit the same register on the same edge, the set wins and busy stays 1.
- Busy lookup: busy1 = busy[chk_a1] and busy2 = busy[chk_a2]. Both are forced to 0 when the checked address is 0. There is no bypass: the bit reads 1 through the edge where it clears.
- Illegal reserve: reserving a register that is already busy, with no clear on that edge, is illegal. The simulation assertion fires and the bit stays 1.
- Reset mid-operation: the registered write is dropped (we3=0 immediately), all busy bits are cleared and rr_ptr returns to 0. Requesters must re-present after reset.

Decomposition:
- Shared package rf_pkg: ADDR_W/DATA_W constants, NUM_REGS=32, and a wb_req_t struct {addr, data} for use by requesters.
- One natural sub-module, rr_arbiter (N, valid vector, ptr in -> one-hot grant plus encoded winner index). It is purely combinational and reusable by other shared-resource blocks.
- The scoreboard stays inline.

Test Plan:
- Single request, req0 addr=5 data=0xDEADBEEF: ready0=1 that cycle; next cycle we3=1, a3=5, wd3=0xDEADBEEF; one cycle later we3=0.
- All three requesters valid continuously after reset: grants in order 0,1,2,0,1,2; no requester waits more than 3 cycles; we3 stays high every cycle.
- Request to addr=0 with data=0x1234: ready asserted, we3 stays 0, busy vector unchanged.
- Reserve reg 7, then chk_a1=7: busy1=1. Requester1 writes reg 7: busy1 stays 1 through the we3 cycle and reads 0 on the cycle after.
- Same edge: we3 commits reg 9 and rsv reserves reg 9 -> busy[9]=1 afterwards. Separately, reserve reg 3 while it is already busy -> assertion fires.
- Assert rst_n=0 mid-stream, with we3=1 and busy bits 4 and 7 set: we3 drops to 0 immediately, busy1/busy2 read 0, and the first grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file writeback path.
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers (x0..x31)
//   wb_req_t : {addr, data} bundle a writeback source can use to build its
//              request before flattening it onto the arbiter ports
//   wrap_inc : modulo-n increment used for round-robin pointers
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic, reusable by any block that
// shares one resource between N clients. The search starts at index ptr and
// wraps modulo N; the first valid client wins.
// Ports:
//   valid  in  N      client i is requesting
//   ptr    in  IDX_W  index searched first
//   grant  out N      one-hot grant, or zero when nobody requests
//   winner out IDX_W  encoded index of the granted client (0 when none)
//   found  out 1      some client was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    int idx;

    // Walk the clients in priority order ptr, ptr+1, ... with wraparound.
    // The found flag locks in the first hit so later clients cannot win.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between N_REQ writeback sources
// using round-robin arbitration, and keeps a pending-write scoreboard so that
// decode can stall on RAW hazards against reserved-but-uncommitted writes.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    in  N_REQ          requester i has a write pending
//   req_ready    out N_REQ          requester i granted this cycle (comb)
//   req_addr     in  N_REQ*ADDR_W   flattened destination registers
//   req_data     in  N_REQ*DATA_W   flattened write data
//   rsv_valid    in  1              decode reserves rsv_addr
//   rsv_addr     in  ADDR_W         register being reserved
//   chk_a1/a2    in  ADDR_W         source registers to look up
//   busy1/busy2  out 1              lookup results (comb, x0 never busy)
//   we3/a3/wd3   out                registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic [ADDR_W-1:0]       chk_a1,
    input  logic [ADDR_W-1:0]       chk_a2,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    we3,
    output logic [ADDR_W-1:0]       a3,
    output logic [DATA_W-1:0]       wd3
);

    import rf_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    next_ptr;
    logic                transfer;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .grant  (req_ready),
        .winner (winner),
        .found  (transfer)
    );

    // The grant is only ever given to a valid requester, so "found" is
    // exactly the transfer condition.
    assign win_addr = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign win_data = req_data[int'(winner)*DATA_W +: DATA_W];
    assign next_ptr = PTR_W'(wrap_inc(int'(winner), N_REQ));

    // Clear for the committing write is applied first so that a reserve of
    // the same register on the same edge overrides it and the bit stays set.
    always_comb begin
        busy_next = busy;
        if (we3) begin
            busy_next[a3] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Writes to x0 are accepted from the requester but never reach the
    // register file; a3/wd3 simply hold whenever nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3    <= 1'b0;
            a3     <= '0;
            wd3    <= '0;
            rr_ptr <= '0;
            busy   <= '0;
        end else begin
            if (transfer) begin
                rr_ptr <= next_ptr;
            end
            if (transfer && (win_addr != '0)) begin
                we3 <= 1'b1;
                a3  <= win_addr;
                wd3 <= win_data;
            end else begin
                we3 <= 1'b0;
            end
            busy <= busy_next;
        end
    end

    // No bypass: a bit still reads 1 during the cycle its write is on we3.
    assign busy1 = (chk_a1 != '0) && busy[chk_a1];
    assign busy2 = (chk_a2 != '0) && busy[chk_a2];

    // Reserving a register that is already pending, without it being
    // released on the same edge, means decode lost track of a hazard.
    illegal_reserve : assert property (@(posedge clk) disable iff (!rst_n)
        !(rsv_valid && (rsv_addr != '0) && busy[rsv_addr] &&
          !(we3 && (a3 == rsv_addr))));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter (N_REQ=3). A table of directed
// vectors with hand-computed expectations, a hand-written reset-in-flight
// sequence, and a randomized phase compared against a behavioural model that
// keeps the requesters in a priority queue and the scoreboard as a bit array.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic [AW-1:0]   chk_a1;
    logic [AW-1:0]   chk_a2;
    logic            busy1;
    logic            busy2;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [DW-1:0]   wd3;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3)
    );

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addrs;
        logic [N*DW-1:0] datas;
        logic            rv;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   c1;
        logic [AW-1:0]   c2;
        logic [N-1:0]    e_ready;
        logic            e_b1;
        logic            e_b2;
        logic            e_we3;
        logic [AW-1:0]   e_a3;
        logic [DW-1:0]   e_wd3;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [N-1:0] valid,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
        input logic rv, input logic [AW-1:0] ra,
        input logic [AW-1:0] c1, input logic [AW-1:0] c2,
        input logic [N-1:0] e_ready, input logic e_b1, input logic e_b2,
        input logic e_we3, input logic [AW-1:0] e_a3, input logic [DW-1:0] e_wd3);
        vec_t t;
        t.valid = valid;
        t.addrs = {a2, a1, a0};
        t.datas = {d2, d1, d0};
        t.rv = rv;   t.ra = ra;
        t.c1 = c1;   t.c2 = c2;
        t.e_ready = e_ready;
        t.e_b1 = e_b1; t.e_b2 = e_b2;
        t.e_we3 = e_we3; t.e_a3 = e_a3; t.e_wd3 = e_wd3;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        req_valid = t.valid;
        req_addr  = t.addrs;
        req_data  = t.datas;
        rsv_valid = t.rv;
        rsv_addr  = t.ra;
        chk_a1    = t.c1;
        chk_a2    = t.c2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            passes++;
        end
    endtask

    // Behavioural model state for the random phase.
    int          order[$];
    bit          m_busy[32];
    logic        m_we3;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;

    initial begin
        vec_t t;
        bit          rq_v[N];
        logic [AW-1:0] rq_a[N];
        logic [DW-1:0] rq_d[N];
        int          wait_cnt[N];
        int          max_wait;
        int          w;

        // Directed vectors, starting right after reset with rr_ptr=0.
        // valid  a0 a1 a2  d0 d1 d2  rv ra  c1 c2  ready b1 b2  we3 a3 wd3
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 32'h11));
            tbl.push_back(mk(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 3'b010, 0, 0, 1, 2, 32'h22));
            tbl.push_back(mk(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 3'b100, 0, 0, 1, 3, 32'h33));
        end
        tbl.push_back(mk(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 5, 32'hDEADBEEF));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(3'b100, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 5, 0, 3'b100, 0, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 3'b000, 0, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(3'b010, 0, 7, 0, 0, 32'h77, 0, 0, 0, 7, 7, 3'b010, 1, 1, 1, 7, 32'h77));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 3'b000, 1, 1, 0, 7, 32'h77));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 3'b000, 0, 0, 0, 7, 32'h77));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 3'b000, 0, 0, 0, 7, 32'h77));
        tbl.push_back(mk(3'b001, 9, 0, 0, 32'h99, 0, 0, 0, 0, 9, 0, 3'b001, 1, 0, 1, 9, 32'h99));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 3'b000, 1, 0, 0, 9, 32'h99));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 3'b000, 1, 1, 0, 9, 32'h99));
        tbl.push_back(mk(3'b101, 4, 0, 6, 32'h44, 0, 32'h66, 0, 0, 0, 0, 3'b100, 0, 0, 1, 6, 32'h66));
        tbl.push_back(mk(3'b001, 4, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 4, 32'h44));

        // Reset state; ready still follows the live inputs from rr_ptr=0.
        t = mk(3'b110, 0, 1, 2, 0, 0, 0, 0, 0, 4, 7, 0, 0, 0, 0, 0, 0);
        applyStimulus(t);
        #1;
        checkOutput("reset_we3", we3, 0);
        checkOutput("reset_a3", a3, 0);
        checkOutput("reset_wd3", wd3, 0);
        checkOutput("reset_busy1", busy1, 0);
        checkOutput("reset_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_ready);
            checkOutput($sformatf("tbl%0d_busy1", i), busy1, tbl[i].e_b1);
            checkOutput($sformatf("tbl%0d_busy2", i), busy2, tbl[i].e_b2);
            @(posedge clk); #1;
            checkOutput($sformatf("tbl%0d_we3", i), we3, tbl[i].e_we3);
            checkOutput($sformatf("tbl%0d_a3", i), a3, tbl[i].e_a3);
            checkOutput($sformatf("tbl%0d_wd3", i), wd3, tbl[i].e_wd3);
        end

        // Reset while a write is in flight and registers 4 and 7 are pending.
        // rr_ptr is 1 here; granting requester 1 leaves it at 2.
        applyStimulus(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        applyStimulus(mk(3'b010, 0, 1, 0, 0, 32'hAA, 0, 1, 7, 4, 7, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        checkOutput("rst_pre_we3", we3, 1);
        checkOutput("rst_pre_busy1", busy1, 1);
        checkOutput("rst_pre_busy2", busy2, 1);
        applyStimulus(mk(3'b110, 0, 2, 3, 0, 32'hB2, 32'hB3, 0, 0, 4, 7, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we3", we3, 0);
        checkOutput("rst_mid_busy1", busy1, 0);
        checkOutput("rst_mid_busy2", busy2, 0);
        checkOutput("rst_mid_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_rel_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        checkOutput("rst_rel_we3", we3, 1);
        checkOutput("rst_rel_a3", a3, 2);
        checkOutput("rst_rel_wd3", wd3, 32'hB2);

        // Fresh reset before the randomized phase so the model starts clean.
        applyStimulus(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        order = {0, 1, 2};
        foreach (m_busy[k]) m_busy[k] = 1'b0;
        m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0;
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; wait_cnt[i] = 0;
        end
        max_wait = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            // Requesters: hold until granted, occasionally withdraw.
            for (int i = 0; i < N; i++) begin
                if (rq_v[i]) begin
                    if ($urandom_range(7) == 0) begin
                        rq_v[i] = 1'b0;
                        wait_cnt[i] = 0;
                    end
                end else if ($urandom_range(1) == 1) begin
                    rq_v[i] = 1'b1;
                    rq_a[i] = ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom_range(31));
                    rq_d[i] = $urandom;
                end
            end
            t.valid = '0;
            for (int i = 0; i < N; i++) begin
                t.valid[i] = rq_v[i];
                t.addrs[i*AW +: AW] = rq_a[i];
                t.datas[i*DW +: DW] = rq_d[i];
            end
            t.rv = ($urandom_range(2) == 0);
            t.ra = AW'($urandom_range(31));
            if (m_busy[t.ra] && !(m_we3 && m_a3 == t.ra)) t.rv = 1'b0;
            t.c1 = ($urandom_range(3) == 0) ? m_a3 : AW'($urandom_range(31));
            t.c2 = AW'($urandom_range(31));
            applyStimulus(t);
            #1;

            w = -1;
            foreach (order[k]) begin
                if (w < 0 && rq_v[order[k]]) w = order[k];
            end
            checkOutput("rnd_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
            checkOutput("rnd_busy1", busy1, (t.c1 != 0) && m_busy[t.c1]);
            checkOutput("rnd_busy2", busy2, (t.c2 != 0) && m_busy[t.c2]);

            // Scoreboard: release the committing write, then apply the reserve.
            if (m_we3) m_busy[m_a3] = 1'b0;
            if (t.rv && t.ra != 0) m_busy[t.ra] = 1'b1;

            for (int i = 0; i < N; i++) if (rq_v[i]) wait_cnt[i]++;
            if (w >= 0) begin
                while (order[0] != w) order.push_back(order.pop_front());
                order.push_back(order.pop_front());
                if (wait_cnt[w] > max_wait) max_wait = wait_cnt[w];
                wait_cnt[w] = 0;
                rq_v[w] = 1'b0;
                if (rq_a[w] != 0) begin
                    m_we3 = 1'b1; m_a3 = rq_a[w]; m_wd3 = rq_d[w];
                end else begin
                    m_we3 = 1'b0;
                end
            end else begin
                m_we3 = 1'b0;
            end

            @(posedge clk); #1;
            checkOutput("rnd_we3", we3, m_we3);
            checkOutput("rnd_a3", a3, m_a3);
            checkOutput("rnd_wd3", wd3, m_wd3);
        end
        checkOutput("rnd_max_wait_ok", (max_wait <= N), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
